// File: rtl/instr_mem_if.sv
// Load-handshake and fetch-side bus of the instruction memory loader.
// Master = loader/IF side, slave = the memory.
interface instr_mem_if #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8,
    parameter int N_WORDS = 64
);
    localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
    localparam int NB_ADDRESS     = $clog2(N_WORDS * BYTES_PER_WORD);
    localparam int NB_WORD_ADDR   = $clog2(N_WORDS);

    logic                    i_load_start;
    logic                    i_load_valid;
    logic [NB_BYTE-1:0]      i_load_byte;
    logic                    o_load_ready;
    logic                    i_load_done;
    logic                    i_read_enable;
    logic [NB_ADDRESS-1:0]   i_read_address;
    logic [NB_DATA-1:0]      o_read_instruction;
    logic                    o_misaligned;
    logic                    o_is_program_end;
    logic [NB_WORD_ADDR:0]   o_loaded_words;
    logic                    o_overflow;
    logic                    o_busy;

    modport master (
        output i_load_start, i_load_valid, i_load_byte, i_load_done,
               i_read_enable, i_read_address,
        input  o_load_ready, o_read_instruction, o_misaligned,
               o_is_program_end, o_loaded_words, o_overflow, o_busy
    );

    modport slave (
        input  i_load_start, i_load_valid, i_load_byte, i_load_done,
               i_read_enable, i_read_address,
        output o_load_ready, o_read_instruction, o_misaligned,
               o_is_program_end, o_loaded_words, o_overflow, o_busy
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Word-organised instruction memory with a byte-serial big-endian loader.
// Optional debug read-back port enabled by defining INSTR_MEM_DEBUG_READ_EN.
module instr_mem_loader #(
    parameter int NB_DATA         = 32,
    parameter int NB_BYTE         = 8,
    parameter int N_WORDS         = 64,
    parameter int BYTES_PER_WORD  = NB_DATA / NB_BYTE,
    parameter int NB_ADDRESS      = $clog2(N_WORDS * BYTES_PER_WORD),
    parameter int NB_WORD_ADDR    = $clog2(N_WORDS),
    parameter int END_SLACK_WORDS = 3
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    instr_mem_if.slave              bus
`ifdef INSTR_MEM_DEBUG_READ_EN
    ,
    input  logic [NB_WORD_ADDR-1:0] i_dbg_word_addr,
    output logic [NB_DATA-1:0]      o_dbg_word
`endif
);
    localparam int NB_OFF = $clog2(BYTES_PER_WORD);
    localparam int NB_CNT = $clog2(BYTES_PER_WORD + 1);
    localparam int NB_CMP = NB_WORD_ADDR + 2;

    localparam logic [NB_WORD_ADDR:0] FULL_WORDS = (NB_WORD_ADDR+1)'(N_WORDS);
    localparam logic [NB_CNT-1:0]     LAST_CNT   = NB_CNT'(BYTES_PER_WORD);
    localparam logic [NB_CMP-1:0]     SLACK      = NB_CMP'(END_SLACK_WORDS);

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_LOAD, ST_RUN} state_t;

    state_t                  state;
    logic                    pending_load;
    logic [NB_WORD_ADDR-1:0] clear_ptr;
    logic [NB_CNT-1:0]       byte_cnt;
    logic [NB_DATA-1:0]      asm_word;
    logic [NB_WORD_ADDR:0]   loaded_words;
    logic                    overflow;
    logic [NB_DATA-1:0]      mem [N_WORDS];

    logic                    full;
    logic                    load_ready;
    logic                    accept;
    logic [NB_DATA-1:0]      placed;
    logic [NB_DATA-1:0]      asm_next;
    logic [NB_CNT-1:0]       cnt_next;
    logic                    word_done;
    logic                    flush;
    logic                    load_write;
    logic                    start_clear;

    logic                    wr_en;
    logic [NB_WORD_ADDR-1:0] wr_addr;
    logic [NB_DATA-1:0]      wr_data;

    logic [NB_WORD_ADDR-1:0] word_idx;

    assign full       = (loaded_words == FULL_WORDS);
    assign load_ready = (state == ST_LOAD) && !full;
    assign accept     = load_ready && bus.i_load_valid;

    // Byte k lands k byte-lanes below the MSB lane (big-endian assembly).
    assign placed   = {bus.i_load_byte, {(NB_DATA-NB_BYTE){1'b0}}} >> (byte_cnt * NB_BYTE);
    assign asm_next = accept ? (asm_word | placed) : asm_word;
    assign cnt_next = accept ? (byte_cnt + 1'b1) : byte_cnt;

    assign word_done   = (cnt_next == LAST_CNT);
    assign flush       = bus.i_load_done && (cnt_next != '0) && !word_done;
    assign load_write  = (state == ST_LOAD) && !bus.i_load_start && (word_done || flush) && !full;
    assign start_clear = bus.i_load_start && (state != ST_CLEAR);

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clear_ptr;
        wr_data = '0;
        if (!i_reset) begin
            if (state == ST_CLEAR) begin
                wr_en = 1'b1;
            end else if (load_write) begin
                wr_en   = 1'b1;
                wr_addr = loaded_words[NB_WORD_ADDR-1:0];
                wr_data = asm_next;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= ST_CLEAR;
            pending_load <= 1'b0;
            clear_ptr    <= '0;
            byte_cnt     <= '0;
            asm_word     <= '0;
            loaded_words <= '0;
            overflow     <= 1'b0;
        end else if (start_clear) begin
            state        <= ST_CLEAR;
            pending_load <= 1'b1;
            clear_ptr    <= '0;
            byte_cnt     <= '0;
            asm_word     <= '0;
            loaded_words <= '0;
            overflow     <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clear_ptr <= clear_ptr + 1'b1;
                    if (bus.i_load_start) pending_load <= 1'b1;
                    if (clear_ptr == NB_WORD_ADDR'(N_WORDS - 1)) begin
                        state        <= (pending_load || bus.i_load_start) ? ST_LOAD : ST_IDLE;
                        pending_load <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (load_write) loaded_words <= loaded_words + 1'b1;
                    if (bus.i_load_valid && full) overflow <= 1'b1;
                    if (word_done || bus.i_load_done) begin
                        asm_word <= '0;
                        byte_cnt <= '0;
                    end else begin
                        asm_word <= asm_next;
                        byte_cnt <= cnt_next;
                    end
                    if (bus.i_load_done) state <= ST_RUN;
                end
                ST_IDLE, ST_RUN: ;
                default: state <= ST_CLEAR;
            endcase
        end
    end

    assign bus.o_load_ready   = load_ready;
    assign bus.o_busy         = (state == ST_CLEAR);
    assign bus.o_loaded_words = loaded_words;
    assign bus.o_overflow     = overflow;

    assign word_idx = bus.i_read_address[NB_ADDRESS-1:NB_OFF];

    // Fetch returns zero outside RUN so a half-loaded image is never executed.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            bus.o_read_instruction <= '0;
            bus.o_misaligned       <= 1'b0;
        end else if (bus.i_read_enable) begin
            bus.o_read_instruction <= (state == ST_RUN) ? mem[word_idx] : '0;
            bus.o_misaligned       <= |bus.i_read_address[NB_OFF-1:0];
        end
    end

    // Widened compare so loaded_words + slack never wraps.
    assign bus.o_is_program_end = (state == ST_RUN) &&
        ((NB_CMP'(word_idx) >= (NB_CMP'(loaded_words) + SLACK)) || (word_idx == '1));

`ifdef INSTR_MEM_DEBUG_READ_EN
    always_ff @(posedge i_clock) begin
        if (i_reset) o_dbg_word <= '0;
        else         o_dbg_word <= mem[i_dbg_word_addr];
    end
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench: 64-word memory for load/read/end-flag/restart tests,
// a 4-word instance for the overflow test.
module tb_instr_mem_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_mem_if #(.NB_DATA(32), .NB_BYTE(8), .N_WORDS(64)) mb ();
    instr_mem_if #(.NB_DATA(32), .NB_BYTE(8), .N_WORDS(4))  sb ();

`ifdef INSTR_MEM_DEBUG_READ_EN
    logic [5:0]  m_dbg_addr = '0;
    logic [31:0] m_dbg_word;
    logic [1:0]  s_dbg_addr = '0;
    logic [31:0] s_dbg_word;
`endif

    instr_mem_loader #(.NB_DATA(32), .NB_BYTE(8), .N_WORDS(64), .END_SLACK_WORDS(3)) dut_m (
        .i_clock(clk), .i_reset(rst), .bus(mb)
`ifdef INSTR_MEM_DEBUG_READ_EN
        , .i_dbg_word_addr(m_dbg_addr), .o_dbg_word(m_dbg_word)
`endif
    );

    instr_mem_loader #(.NB_DATA(32), .NB_BYTE(8), .N_WORDS(4), .END_SLACK_WORDS(3)) dut_s (
        .i_clock(clk), .i_reset(rst), .bus(sb)
`ifdef INSTR_MEM_DEBUG_READ_EN
        , .i_dbg_word_addr(s_dbg_addr), .o_dbg_word(s_dbg_word)
`endif
    );

    typedef struct {
        logic        en;
        logic [7:0]  addr;
        logic [31:0] instr;
        logic        mis;
        logic        pend;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    vec_t prog1 [11];
    vec_t prog2 [4];
    vec_t prog3 [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        exp_t e;
        mb.i_read_enable  = v.en;
        mb.i_read_address = v.addr;
        #1;
        check({tag, "_end"}, 64'(mb.o_is_program_end), 64'(v.pend));
        sbq.push_back('{v.instr, v.mis});
        tick();
        e = sbq.pop_front();
        check({tag, "_instr"}, 64'(mb.o_read_instruction), 64'(e.instr));
        check({tag, "_mis"}, 64'(mb.o_misaligned), 64'(e.mis));
        mb.i_read_enable = 1'b0;
    endtask

    task automatic wait_clear_m(input string name, input int exp);
        int n = 0;
        while (mb.o_busy === 1'b1 && n < 300) begin
            n++;
            tick();
        end
        check(name, 64'(n), 64'(exp));
    endtask

    task automatic send_m(input logic [7:0] b, input logic done);
        mb.i_load_valid = 1'b1;
        mb.i_load_byte  = b;
        mb.i_load_done  = done;
        tick();
        mb.i_load_valid = 1'b0;
        mb.i_load_done  = 1'b0;
    endtask

    task automatic start_m();
        mb.i_load_start = 1'b1;
        tick();
        mb.i_load_start = 1'b0;
    endtask

    task automatic done_m();
        mb.i_load_done = 1'b1;
        tick();
        mb.i_load_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        prog1[0]  = '{1'b1, 8'd0,   32'h8C010004, 1'b0, 1'b0};
        prog1[1]  = '{1'b1, 8'd4,   32'h00221820, 1'b0, 1'b0};
        prog1[2]  = '{1'b0, 8'd0,   32'h00221820, 1'b0, 1'b0};
        prog1[3]  = '{1'b0, 8'd8,   32'h00221820, 1'b0, 1'b0};
        prog1[4]  = '{1'b1, 8'd6,   32'h00221820, 1'b1, 1'b0};
        prog1[5]  = '{1'b0, 8'd1,   32'h00221820, 1'b1, 1'b0};
        prog1[6]  = '{1'b1, 8'd16,  32'h00000000, 1'b0, 1'b0};
        prog1[7]  = '{1'b1, 8'd20,  32'h00000000, 1'b0, 1'b1};
        prog1[8]  = '{1'b1, 8'd252, 32'h00000000, 1'b0, 1'b1};
        prog1[9]  = '{1'b1, 8'd253, 32'h00000000, 1'b1, 1'b1};
        prog1[10] = '{1'b1, 8'd8,   32'h00000000, 1'b0, 1'b0};

        prog2[0]  = '{1'b1, 8'd0,   32'hAABBCCDD, 1'b0, 1'b0};
        prog2[1]  = '{1'b1, 8'd4,   32'hEE000000, 1'b0, 1'b0};
        prog2[2]  = '{1'b1, 8'd8,   32'h00000000, 1'b0, 1'b0};
        prog2[3]  = '{1'b1, 8'd20,  32'h00000000, 1'b0, 1'b1};

        prog3[0]  = '{1'b1, 8'd0,   32'h00000000, 1'b0, 1'b0};
        prog3[1]  = '{1'b1, 8'd8,   32'h00000000, 1'b0, 1'b0};
        prog3[2]  = '{1'b1, 8'd12,  32'h00000000, 1'b0, 1'b1};

        mb.i_load_start = 0; mb.i_load_valid = 0; mb.i_load_byte = 0; mb.i_load_done = 0;
        mb.i_read_enable = 0; mb.i_read_address = 0;
        sb.i_load_start = 0; sb.i_load_valid = 0; sb.i_load_byte = 0; sb.i_load_done = 0;
        sb.i_read_enable = 0; sb.i_read_address = 0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_instr",    64'(mb.o_read_instruction), 64'h0);
        check("rst_mis",      64'(mb.o_misaligned), 64'h0);
        check("rst_loaded",   64'(mb.o_loaded_words), 64'h0);
        check("rst_overflow", 64'(mb.o_overflow), 64'h0);
        check("rst_busy",     64'(mb.o_busy), 64'h1);
        check("rst_ready",    64'(mb.o_load_ready), 64'h0);
        rst = 1'b0;
        wait_clear_m("clear_after_reset", 64);
        check("idle_busy",  64'(mb.o_busy), 64'h0);
        check("idle_ready", 64'(mb.o_load_ready), 64'h0);
        check("idle_end",   64'(mb.o_is_program_end), 64'h0);

        // Full-word program
        start_m();
        wait_clear_m("clear_load1", 64);
        check("load1_ready", 64'(mb.o_load_ready), 64'h1);
        send_m(8'h8C, 0); send_m(8'h01, 0); send_m(8'h00, 0); send_m(8'h04, 0);
        send_m(8'h00, 0); send_m(8'h22, 0); send_m(8'h18, 0); send_m(8'h20, 0);
        check("load1_loaded_pre", 64'(mb.o_loaded_words), 64'h2);
        done_m();
        check("load1_loaded", 64'(mb.o_loaded_words), 64'h2);
        for (int i = 0; i < 11; i++) apply_vec($sformatf("p1_%0d", i), prog1[i]);

        // Restart from RUN; fetch must be gated while clearing
        start_m();
        apply_vec("clear_gate", '{1'b1, 8'd4, 32'h0, 1'b0, 1'b0});
        wait_clear_m("clear_load2", 63);
        check("load2_loaded0", 64'(mb.o_loaded_words), 64'h0);
        send_m(8'hAA, 0); send_m(8'hBB, 0); send_m(8'hCC, 0); send_m(8'hDD, 0);
        send_m(8'hEE, 1);
        check("load2_loaded", 64'(mb.o_loaded_words), 64'h2);
        for (int i = 0; i < 4; i++) apply_vec($sformatf("p2_%0d", i), prog2[i]);

        // Restart mid-LOAD after 3 bytes
        start_m();
        wait_clear_m("clear_load3", 64);
        send_m(8'h11, 0); send_m(8'h22, 0); send_m(8'h33, 0);
        start_m();
        check("restart_busy", 64'(mb.o_busy), 64'h1);
        wait_clear_m("clear_restart", 64);
        check("restart_ready",  64'(mb.o_load_ready), 64'h1);
        check("restart_loaded", 64'(mb.o_loaded_words), 64'h0);
        done_m();
        for (int i = 0; i < 3; i++) apply_vec($sformatf("p3_%0d", i), prog3[i]);

        // Reset mid-LOAD ends in IDLE after the clear
        start_m();
        wait_clear_m("clear_load4", 64);
        send_m(8'h55, 0); send_m(8'h66, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_clear_m("clear_after_reset2", 64);
        check("reset2_ready",  64'(mb.o_load_ready), 64'h0);
        check("reset2_busy",   64'(mb.o_busy), 64'h0);
        check("reset2_loaded", 64'(mb.o_loaded_words), 64'h0);

        // Overflow on the 4-word instance
        begin
            int n = 0;
            exp_t e;
            sb.i_load_start = 1'b1;
            tick();
            sb.i_load_start = 1'b0;
            while (sb.o_busy === 1'b1 && n < 50) begin
                n++;
                tick();
            end
            check("ov_clear_cycles", 64'(n), 64'd4);
            for (int i = 0; i < 16; i++) begin
                check($sformatf("ov_ready_%0d", i), 64'(sb.o_load_ready), 64'h1);
                sb.i_load_valid = 1'b1;
                sb.i_load_byte  = 8'(i + 1);
                tick();
            end
            sb.i_load_valid = 1'b0;
            check("ov_ready_full", 64'(sb.o_load_ready), 64'h0);
            check("ov_flag_pre",   64'(sb.o_overflow), 64'h0);
            check("ov_loaded_pre", 64'(sb.o_loaded_words), 64'h4);
            sb.i_load_valid = 1'b1;
            sb.i_load_byte  = 8'h11;
            tick();
            sb.i_load_valid = 1'b0;
            check("ov_flag",   64'(sb.o_overflow), 64'h1);
            check("ov_loaded", 64'(sb.o_loaded_words), 64'h4);
            sb.i_load_done = 1'b1;
            tick();
            sb.i_load_done = 1'b0;
            check("ov_flag_sticky", 64'(sb.o_overflow), 64'h1);

            sb.i_read_enable  = 1'b1;
            sb.i_read_address = 4'd12;
            #1;
            check("ov_end_last", 64'(sb.o_is_program_end), 64'h1);
            sbq.push_back('{32'h0D0E0F10, 1'b0});
            tick();
            e = sbq.pop_front();
            check("ov_word3", 64'(sb.o_read_instruction), 64'(e.instr));
            sb.i_read_address = 4'd0;
            #1;
            check("ov_end_first", 64'(sb.o_is_program_end), 64'h0);
            sbq.push_back('{32'h01020304, 1'b0});
            tick();
            e = sbq.pop_front();
            check("ov_word0", 64'(sb.o_read_instruction), 64'(e.instr));
            sb.i_read_enable = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
